hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULDIV_CYCLES, default 32, mult/div execution latency in cycles (legal range 2..63).
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 idRs  in  5  rs field of instruction held in IF/ID.
REQ-006 idRt  in  5  rt field of instruction held in IF/ID.
REQ-007 idUsesHiLo  in  1  IF/ID instruction is mfhi/mflo/mult/div.
REQ-008 exMemRead  in  1  instruction in ID/EX is a load.
REQ-009 exRt  in  5  destination register of the ID/EX load.
REQ-010 exMdStart  in  1  instruction in ID/EX is mult/div, issuing this cycle.
REQ-011 branchTaken  in  1  branch/jump resolved taken in EX this cycle.
REQ-012 pcWrite  out  1  PC update enable.
REQ-013 ifidWrite  out  1  IF/ID load enable (0 = hold).
REQ-014 ifidFlush  out  1  IF/ID clear to NOP on next edge.
REQ-015 idexBubble  out  1  insert NOP into ID/EX on next edge.
REQ-016 hiloWrite  out  1  one-cycle strobe committing mult/div result to HI/LO.
REQ-017 mdBusy  out  1  mult/div unit occupied.
REQ-018 stallCount  out  CNT_W  saturating count of stall cycles.

Function
REQ-019 FSM states SHALL be RUN, MD_BUSY, MD_DONE; state register plus a 6-bit down-counter mdCnt.
REQ-020 Idle outputs SHALL be pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, hiloWrite=0.
REQ-021 Load-use: exMemRead=1, exRt!=0, exRt equal to idRs or idRt SHALL give pcWrite=0, ifidWrite=0, idexBubble=1 in the same cycle (combinational); exRt=0 SHALL never stall.
REQ-022 branchTaken=1 SHALL give ifidFlush=1, idexBubble=1, pcWrite=1 in the same cycle and SHALL override any load-use or HI/LO stall.
REQ-023 RUN: exMdStart=1 with branchTaken=0 SHALL load mdCnt=MULDIV_CYCLES-2 and enter MD_BUSY next edge; exMdStart with branchTaken=1 SHALL be ignored.
REQ-024 MD_BUSY: mdCnt SHALL decrement each cycle; at mdCnt=0 next state SHALL be MD_DONE.
REQ-025 MD_DONE: hiloWrite=1 for exactly this cycle; next state RUN.
REQ-026 mdBusy SHALL be 1 in MD_BUSY and MD_DONE, 0 in RUN; total occupancy = MULDIV_CYCLES cycles from issue edge.
REQ-027 idUsesHiLo=1 while mdBusy=1 SHALL stall (pcWrite=0, ifidWrite=0, idexBubble=1) unless branchTaken=1.
REQ-028 branchTaken during MD_BUSY SHALL NOT abort the counter (issued op completes).
REQ-029 stallCount SHALL increment on each cycle with pcWrite=0 and saturate at all-ones.
REQ-030 Simultaneous load-use and HI/LO stall SHALL count as one stall cycle.

Reset
REQ-031 rst=0 at a rising edge SHALL set state=RUN, mdCnt=0, stallCount=0, aborting any mult/div in flight (no hiloWrite).
REQ-032 While rst=0, all outputs SHALL present idle values and mdBusy=0.

Structure
REQ-033 State encoding (RUN=0, MD_BUSY=1, MD_DONE=2), ZERO_REG=5'd0 and MULDIV_CYCLES default SHALL live in shared package mips_pkg.
REQ-034 Mult/div countdown SHALL be a sub-module md_counter (load, decrement, zero flag); hazard compare logic stays in hazard_ctrl.

Verification
REQ-035 exMemRead=1, exRt=8, idRs=8 -> pcWrite=0, ifidWrite=0, idexBubble=1 that cycle; stallCount 0->1.
REQ-036 exMemRead=1, exRt=0, idRs=0 -> idle outputs, stallCount unchanged.
REQ-037 exMdStart pulse, MULDIV_CYCLES=32 -> mdBusy high 32 cycles, hiloWrite high only in 32nd; idUsesHiLo=1 throughout -> 32 stall cycles.
REQ-038 branchTaken=1 with load-use active -> ifidFlush=1, idexBubble=1, pcWrite=1, no count.
REQ-039 rst=0 at cycle 10 of MD_BUSY -> next cycle mdBusy=0, state RUN, no hiloWrite ever.
REQ-040 CNT_W=4, 20 consecutive stall cycles -> stallCount holds 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline-control definitions: mult/div FSM encoding, register zero and latency defaults.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [4:0]  ZERO_REG          = 5'd0;
    localparam int unsigned MULDIV_CYCLES_DEF = 32;
    localparam int unsigned MD_CNT_W          = 6;

endpackage

// File: rtl/md_counter.sv
// Mult/div occupancy down-counter: parallel load, decrement, zero flag.
module md_counter
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [MD_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - MD_CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, branch flush, mult/div occupancy tracking.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesHiLo,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             exMdStart,
    input  logic             branchTaken,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             hiloWrite,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount
);

    // Issue edge counts as the first busy cycle and MD_DONE as the last.
    localparam logic [MD_CNT_W-1:0] MD_LOAD_VAL = MD_CNT_W'(MULDIV_CYCLES - 2);

    md_state_t        state, state_next;
    logic             md_load, md_dec, md_zero;
    logic             load_use, hilo_stall, busy;
    logic [CNT_W-1:0] stall_cnt;

    md_counter u_md_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (md_load),
        .load_val (MD_LOAD_VAL),
        .dec      (md_dec),
        .zero     (md_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        md_load    = 1'b0;
        md_dec     = 1'b0;
        case (state)
            RUN: begin
                if (exMdStart && !branchTaken) begin
                    md_load    = 1'b1;
                    state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_dec = 1'b1;
                if (md_zero) state_next = MD_DONE;
            end
            MD_DONE: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign busy       = (state != RUN);
    assign load_use   = exMemRead && (exRt != ZERO_REG) && ((exRt == idRs) || (exRt == idRt));
    assign hilo_stall = idUsesHiLo && busy;

    // Reset forces idle outputs so a held reset never stalls or commits HI/LO.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        hiloWrite  = 1'b0;
        mdBusy     = 1'b0;
        if (rst) begin
            mdBusy    = busy;
            hiloWrite = (state == MD_DONE);
            if (branchTaken) begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
            end else if (load_use || hilo_stall) begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexBubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pcWrite && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance plus a 2-cycle / 4-bit-counter instance.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_hilo, ex_mem_read, ex_md_start, branch_taken;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_hilo_write, a_md_busy;
    logic [15:0] a_stall_count;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_hilo_write, b_md_busy;
    logic [3:0]  b_stall_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .idRs(id_rs), .idRt(id_rt), .idUsesHiLo(id_uses_hilo),
        .exMemRead(ex_mem_read), .exRt(ex_rt), .exMdStart(ex_md_start), .branchTaken(branch_taken),
        .pcWrite(a_pc_write), .ifidWrite(a_ifid_write), .ifidFlush(a_ifid_flush),
        .idexBubble(a_idex_bubble), .hiloWrite(a_hilo_write), .mdBusy(a_md_busy),
        .stallCount(a_stall_count)
    );

    hazard_ctrl #(.MULDIV_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .idRs(id_rs), .idRt(id_rt), .idUsesHiLo(id_uses_hilo),
        .exMemRead(ex_mem_read), .exRt(ex_rt), .exMdStart(ex_md_start), .branchTaken(branch_taken),
        .pcWrite(b_pc_write), .ifidWrite(b_ifid_write), .ifidFlush(b_ifid_flush),
        .idexBubble(b_idex_bubble), .hiloWrite(b_hilo_write), .mdBusy(b_md_busy),
        .stallCount(b_stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_hilo = 1'b0; ex_mem_read = 1'b0; ex_md_start = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_hilo = 1'b1; ex_md_start = 1'b1;
        step();
        step();
        n_vec++; if (a_pc_write !== 1'b1) begin n_err++; $display("FAIL rst_pc: got %b want 1", a_pc_write); end
        n_vec++; if (a_ifid_write !== 1'b1) begin n_err++; $display("FAIL rst_ifid: got %b want 1", a_ifid_write); end
        n_vec++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL rst_bubble: got %b want 0", a_idex_bubble); end
        n_vec++; if (a_ifid_flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", a_ifid_flush); end
        n_vec++; if (a_hilo_write !== 1'b0) begin n_err++; $display("FAIL rst_hilo: got %b want 0", a_hilo_write); end
        n_vec++; if (a_md_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", a_md_busy); end
        n_vec++; if (a_stall_count !== 16'd0) begin n_err++; $display("FAIL rst_cnt_a: got %0d want 0", a_stall_count); end
        n_vec++; if (b_stall_count !== 4'd0) begin n_err++; $display("FAIL rst_cnt_b: got %0d want 0", b_stall_count); end
        clear_inputs();
        rst = 1'b1;
        step();
        n_vec++; if (a_md_busy !== 1'b0) begin n_err++; $display("FAIL rst_rel_busy: got %b want 0", a_md_busy); end
        n_vec++; if (a_stall_count !== 16'd0) begin n_err++; $display("FAIL rst_rel_cnt: got %0d want 0", a_stall_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        #1;
        n_vec++; if (a_pc_write !== 1'b0) begin n_err++; $display("FAIL lu_rs_pc: got %b want 0", a_pc_write); end
        n_vec++; if (a_ifid_write !== 1'b0) begin n_err++; $display("FAIL lu_rs_ifid: got %b want 0", a_ifid_write); end
        n_vec++; if (a_idex_bubble !== 1'b1) begin n_err++; $display("FAIL lu_rs_bubble: got %b want 1", a_idex_bubble); end
        n_vec++; if (a_ifid_flush !== 1'b0) begin n_err++; $display("FAIL lu_rs_flush: got %b want 0", a_ifid_flush); end
        step();
        clear_inputs();
        #1;
        n_vec++; if (a_stall_count !== 16'd1) begin n_err++; $display("FAIL lu_rs_cnt: got %0d want 1", a_stall_count); end
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9;
        #1;
        n_vec++; if (a_idex_bubble !== 1'b1) begin n_err++; $display("FAIL lu_rt_bubble: got %b want 1", a_idex_bubble); end
        step();
        ex_rt = 5'd9; id_rs = 5'd8; id_rt = 5'd7;
        #1;
        n_vec++; if (a_pc_write !== 1'b1) begin n_err++; $display("FAIL lu_nomatch_pc: got %b want 1", a_pc_write); end
        ex_mem_read = 1'b0; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        n_vec++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL lu_noload_bubble: got %b want 0", a_idex_bubble); end
        step();
        n_vec++; if (a_stall_count !== 16'd2) begin n_err++; $display("FAIL lu_cnt2: got %0d want 2", a_stall_count); end
        clear_inputs();
    endtask

    task automatic test_zero_reg();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        n_vec++; if (a_pc_write !== 1'b1) begin n_err++; $display("FAIL zr_pc: got %b want 1", a_pc_write); end
        n_vec++; if (a_ifid_write !== 1'b1) begin n_err++; $display("FAIL zr_ifid: got %b want 1", a_ifid_write); end
        n_vec++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL zr_bubble: got %b want 0", a_idex_bubble); end
        step();
        n_vec++; if (a_stall_count !== 16'd0) begin n_err++; $display("FAIL zr_cnt: got %0d want 0", a_stall_count); end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
        #1;
        n_vec++; if (a_ifid_flush !== 1'b1) begin n_err++; $display("FAIL br_flush: got %b want 1", a_ifid_flush); end
        n_vec++; if (a_idex_bubble !== 1'b1) begin n_err++; $display("FAIL br_bubble: got %b want 1", a_idex_bubble); end
        n_vec++; if (a_pc_write !== 1'b1) begin n_err++; $display("FAIL br_pc: got %b want 1", a_pc_write); end
        step();
        clear_inputs();
        n_vec++; if (a_stall_count !== 16'd0) begin n_err++; $display("FAIL br_cnt: got %0d want 0", a_stall_count); end
        ex_md_start = 1'b1; branch_taken = 1'b1;
        step();
        clear_inputs();
        #1;
        n_vec++; if (a_md_busy !== 1'b0) begin n_err++; $display("FAIL br_md_a: got %b want 0", a_md_busy); end
        n_vec++; if (b_md_busy !== 1'b0) begin n_err++; $display("FAIL br_md_b: got %b want 0", b_md_busy); end
    endtask

    task automatic test_muldiv();
        logic exp;
        do_reset();
        ex_md_start = 1'b1;
        #1;
        n_vec++; if (a_md_busy !== 1'b0) begin n_err++; $display("FAIL md_pre_busy: got %b want 0", a_md_busy); end
        step();
        ex_md_start = 1'b0;
        id_uses_hilo = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            branch_taken = (i == 5);
            #1;
            n_vec++; if (a_md_busy !== 1'b1) begin n_err++; $display("FAIL md_busy_a c%0d: got %b want 1", i, a_md_busy); end
            exp = (i == 32);
            n_vec++; if (a_hilo_write !== exp) begin n_err++; $display("FAIL md_hilo_a c%0d: got %b want %b", i, a_hilo_write, exp); end
            exp = (i == 5);
            n_vec++; if (a_pc_write !== exp) begin n_err++; $display("FAIL md_pc_a c%0d: got %b want %b", i, a_pc_write, exp); end
            n_vec++; if (a_ifid_flush !== exp) begin n_err++; $display("FAIL md_flush_a c%0d: got %b want %b", i, a_ifid_flush, exp); end
            exp = (i <= 2);
            n_vec++; if (b_md_busy !== exp) begin n_err++; $display("FAIL md_busy_b c%0d: got %b want %b", i, b_md_busy, exp); end
            exp = (i == 2);
            n_vec++; if (b_hilo_write !== exp) begin n_err++; $display("FAIL md_hilo_b c%0d: got %b want %b", i, b_hilo_write, exp); end
            step();
        end
        branch_taken = 1'b0;
        #1;
        n_vec++; if (a_md_busy !== 1'b0) begin n_err++; $display("FAIL md_post_busy: got %b want 0", a_md_busy); end
        n_vec++; if (a_hilo_write !== 1'b0) begin n_err++; $display("FAIL md_post_hilo: got %b want 0", a_hilo_write); end
        n_vec++; if (a_pc_write !== 1'b1) begin n_err++; $display("FAIL md_post_pc: got %b want 1", a_pc_write); end
        n_vec++; if (a_stall_count !== 16'd31) begin n_err++; $display("FAIL md_cnt_a: got %0d want 31", a_stall_count); end
        n_vec++; if (b_stall_count !== 4'd2) begin n_err++; $display("FAIL md_cnt_b: got %0d want 2", b_stall_count); end
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        logic hilo_seen;
        do_reset();
        ex_md_start = 1'b1;
        step();
        ex_md_start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        n_vec++; if (a_md_busy !== 1'b1) begin n_err++; $display("FAIL ab_busy_before: got %b want 1", a_md_busy); end
        rst = 1'b0;
        #1;
        n_vec++; if (a_md_busy !== 1'b0) begin n_err++; $display("FAIL ab_busy_in_rst: got %b want 0", a_md_busy); end
        step();
        rst = 1'b1;
        #1;
        n_vec++; if (a_md_busy !== 1'b0) begin n_err++; $display("FAIL ab_busy_after: got %b want 0", a_md_busy); end
        hilo_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_hilo_write) hilo_seen = 1'b1;
            step();
        end
        n_vec++; if (hilo_seen !== 1'b0) begin n_err++; $display("FAIL ab_hilo: got %b want 0", hilo_seen); end
    endtask

    task automatic test_saturate();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd12; id_rt = 5'd12;
        for (int i = 0; i < 20; i++) step();
        clear_inputs();
        #1;
        n_vec++; if (b_stall_count !== 4'hF) begin n_err++; $display("FAIL sat_cnt_b: got %0d want 15", b_stall_count); end
        n_vec++; if (a_stall_count !== 16'd20) begin n_err++; $display("FAIL sat_cnt_a: got %0d want 20", a_stall_count); end
        step();
        n_vec++; if (b_stall_count !== 4'hF) begin n_err++; $display("FAIL sat_hold_b: got %0d want 15", b_stall_count); end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_muldiv();
        test_reset_abort();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
